// File: rtl/rll_key_pkg.sv
// -----------------------------------------------------------------------------
// rll_key_pkg
// Shared types and constants for the rll32 key loader.
//   state_e      : loader FSM states
//   CHECK_WIDTH  : checksum bits appended after the key
//   FRAME_LEN    : serial frame length for the default 32-bit key
//   cnt_width()  : bit counter width able to hold 0..n inclusive
// -----------------------------------------------------------------------------
package rll_key_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        READY = 2'd3
    } state_e;

    localparam int KEY_WIDTH_DEF = 32;
    localparam int CHECK_WIDTH   = 8;
    localparam int FRAME_LEN     = KEY_WIDTH_DEF + CHECK_WIDTH;

    // Counter must be able to reach n itself, so size for n+1 values.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rll_key_loader_if.sv
// -----------------------------------------------------------------------------
// rll_key_loader_if
// Key source <-> loader bundle.
//   start, bit_in, bit_valid          : serial frame from the key source
//   key_out, key_valid, key_error,
//   busy, locked                      : verified key and status to the core side
// master: key source / test driver.  slave: rll_key_loader.
// -----------------------------------------------------------------------------
interface rll_key_loader_if #(
    parameter int KEY_WIDTH = 32
);
    logic                 start;
    logic                 bit_in;
    logic                 bit_valid;
    logic [KEY_WIDTH-1:0] key_out;
    logic                 key_valid;
    logic                 key_error;
    logic                 busy;
    logic                 locked;

    modport master (
        output start, bit_in, bit_valid,
        input  key_out, key_valid, key_error, busy, locked
    );

    modport slave (
        input  start, bit_in, bit_valid,
        output key_out, key_valid, key_error, busy, locked
    );
endinterface

// File: rtl/rll_key_checksum.sv
// -----------------------------------------------------------------------------
// rll_key_checksum
// Combinational XOR-fold of the key into CHECK_WIDTH-bit chunks (bytes by
// default) and compare against the received checksum.
//   key   : KEY_WIDTH received key bits
//   chk   : CHECK_WIDTH received checksum bits
//   match : 1 when fold(key) == chk
// -----------------------------------------------------------------------------
module rll_key_checksum
    import rll_key_pkg::*;
#(
    parameter int KEY_WIDTH   = 32,
    parameter int CHECK_WIDTH = rll_key_pkg::CHECK_WIDTH
) (
    input  logic [KEY_WIDTH-1:0]   key,
    input  logic [CHECK_WIDTH-1:0] chk,
    output logic                   match
);
    localparam int NCHUNK = KEY_WIDTH / CHECK_WIDTH;

    // Running XOR: acc[g+1] = acc[g] ^ chunk g.
    logic [NCHUNK:0][CHECK_WIDTH-1:0] acc;

    assign acc[0] = '0;

    for (genvar g = 0; g < NCHUNK; g++) begin : g_fold
        assign acc[g+1] = acc[g] ^ key[g*CHECK_WIDTH +: CHECK_WIDTH];
    end

    assign match = (acc[NCHUNK] == chk);
endmodule

// File: rtl/rll_key_loader.sv
// -----------------------------------------------------------------------------
// rll_key_loader
// Receives a serial LSB-first frame {chk, key}, verifies the XOR-fold checksum
// and presents a stable verified key to the locked rll32 core.
//   clk  : single clock
//   rst  : synchronous active-high reset
//   bus  : rll_key_loader_if.slave (start/bit_in/bit_valid in,
//          key_out/key_valid/key_error/busy/locked out)
// key_out only changes on the checksum cycle or on reset, so the core never
// sees a partially shifted key.
// -----------------------------------------------------------------------------
module rll_key_loader
    import rll_key_pkg::*;
#(
    parameter int KEY_WIDTH   = 32,
    parameter int CHECK_WIDTH = rll_key_pkg::CHECK_WIDTH,
    parameter bit ONE_SHOT    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    rll_key_loader_if.slave  bus
);
    localparam int FLEN = KEY_WIDTH + CHECK_WIDTH;
    localparam int CW   = cnt_width(FLEN);

    state_e               state;
    logic [FLEN-1:0]      sr;
    logic [CW-1:0]        cnt;
    logic [KEY_WIDTH-1:0] key_q;
    logic                 valid_q;
    logic                 err_q;
    logic                 busy_q;
    logic                 locked_q;
    logic                 match;

    // Shift right: after FLEN bits the first accepted bit sits in sr[0].
    rll_key_checksum #(
        .KEY_WIDTH   (KEY_WIDTH),
        .CHECK_WIDTH (CHECK_WIDTH)
    ) u_chk (
        .key   (sr[KEY_WIDTH-1:0]),
        .chk   (sr[FLEN-1:KEY_WIDTH]),
        .match (match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            key_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            case (state)
                IDLE, READY: begin
                    // key_out keeps its last value while a new frame loads.
                    if (bus.start && !locked_q) begin
                        state   <= LOAD;
                        sr      <= '0;
                        cnt     <= '0;
                        valid_q <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.start) begin
                        // Restart wins over a bit presented on the same edge.
                        sr  <= '0;
                        cnt <= '0;
                    end else if (bus.bit_valid) begin
                        sr  <= {bus.bit_in, sr[FLEN-1:1]};
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(FLEN - 1))
                            state <= CHECK;
                    end
                end
                CHECK: begin
                    busy_q <= 1'b0;
                    if (match) begin
                        key_q    <= sr[KEY_WIDTH-1:0];
                        valid_q  <= 1'b1;
                        err_q    <= 1'b0;
                        locked_q <= ONE_SHOT;
                        state    <= READY;
                    end else begin
                        key_q   <= '0;
                        valid_q <= 1'b0;
                        err_q   <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.key_out   = key_q;
    assign bus.key_valid = valid_q;
    assign bus.key_error = err_q;
    assign bus.busy      = busy_q;
    assign bus.locked    = locked_q;
endmodule

// File: tb/tb_rll_key_loader.sv
// -----------------------------------------------------------------------------
// tb_rll_key_loader
// Drives one shared serial stream into two loaders (ONE_SHOT=0 and ONE_SHOT=1)
// and compares both against a per-frame reference of the key/checksum rules.
// -----------------------------------------------------------------------------
module tb_rll_key_loader;
    localparam int KW = 32;
    localparam int CW = 8;
    localparam int FL = KW + CW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;

    always #5 clk = ~clk;

    rll_key_loader_if #(.KEY_WIDTH(KW)) if0 ();
    rll_key_loader_if #(.KEY_WIDTH(KW)) if1 ();

    assign if0.start = start;
    assign if0.bit_in = bit_in;
    assign if0.bit_valid = bit_valid;
    assign if1.start = start;
    assign if1.bit_in = bit_in;
    assign if1.bit_valid = bit_valid;

    rll_key_loader #(.KEY_WIDTH(KW), .CHECK_WIDTH(CW), .ONE_SHOT(1'b0)) u_dut0 (
        .clk (clk), .rst (rst), .bus (if0)
    );
    rll_key_loader #(.KEY_WIDTH(KW), .CHECK_WIDTH(CW), .ONE_SHOT(1'b1)) u_dut1 (
        .clk (clk), .rst (rst), .bus (if1)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference state per instance: index 0 = ONE_SHOT 0, 1 = ONE_SHOT 1.
    logic [KW-1:0] m_key [2];
    bit            m_valid [2];
    bit            m_err [2];
    bit            m_lock [2];
    bit            os [2] = '{1'b0, 1'b1};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] fold(input logic [31:0] k);
        return k[7:0] ^ k[15:8] ^ k[23:16] ^ k[31:24];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_key[d] = '0; m_valid[d] = 0; m_err[d] = 0; m_lock[d] = 0;
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".key0"},   if0.key_out,   m_key[0]);
        check({tag, ".vld0"},   if0.key_valid, m_valid[0]);
        check({tag, ".err0"},   if0.key_error, m_err[0]);
        check({tag, ".busy0"},  if0.busy,      0);
        check({tag, ".lock0"},  if0.locked,    m_lock[0]);
        check({tag, ".key1"},   if1.key_out,   m_key[1]);
        check({tag, ".vld1"},   if1.key_valid, m_valid[1]);
        check({tag, ".err1"},   if1.key_error, m_err[1]);
        check({tag, ".busy1"},  if1.busy,      0);
        check({tag, ".lock1"},  if1.locked,    m_lock[1]);
    endtask

    // Accepted start clears valid/error; key_out holds.
    task automatic model_start(output bit act [2]);
        for (int d = 0; d < 2; d++) begin
            act[d] = !m_lock[d];
            if (act[d]) begin m_valid[d] = 0; m_err[d] = 0; end
        end
    endtask

    // Start then n random bits, abandoned mid-frame.
    task automatic partial(input int n);
        bit act [2];
        start = 1; step(); start = 0;
        model_start(act);
        for (int i = 0; i < n; i++) begin
            bit_in = 1'($urandom); bit_valid = 1; step(); bit_valid = 0;
        end
    endtask

    task automatic send_frame(input logic [31:0] key, input logic [7:0] c, input bit gaps);
        logic [FL-1:0] fr;
        bit act [2];
        fr = {c, key};
        // bit_valid on the start edge must be discarded.
        start = 1; bit_valid = 1; bit_in = 1; step(); start = 0; bit_valid = 0;
        model_start(act);
        check("start.vld0", if0.key_valid, m_valid[0]);
        check("start.key0", if0.key_out, m_key[0]);
        check("start.busy0", if0.busy, act[0]);
        check("start.busy1", if1.busy, act[1]);
        for (int i = 0; i < FL; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 5)) begin
                    step();
                    check("gap.busy0", if0.busy, act[0]);
                    check("gap.busy1", if1.busy, act[1]);
                end
            end
            bit_in = fr[i]; bit_valid = 1; step(); bit_valid = 0;
            check("bit.busy0", if0.busy, act[0]);
            check("bit.busy1", if1.busy, act[1]);
            if (i == FL - 1) begin
                check("early.vld0", if0.key_valid, m_valid[0]);
                check("early.key0", if0.key_out, m_key[0]);
            end
        end
        // Start during the checksum cycle must not disturb the result.
        start = 1; step(); start = 0;
        for (int d = 0; d < 2; d++) begin
            if (act[d]) begin
                if (fold(key) == c) begin
                    m_key[d] = key; m_valid[d] = 1; m_err[d] = 0; m_lock[d] = os[d];
                end else begin
                    m_key[d] = '0; m_valid[d] = 0; m_err[d] = 1;
                end
            end
        end
        check_outs("result");
    endtask

    initial begin
        logic [31:0] k;
        logic [7:0]  c;
        model_reset();
        rst = 1; step(); step(); rst = 0;
        repeat (10) step();
        check_outs("reset");

        send_frame(32'h1234_5678, 8'h08, 0);
        check("t1.key0", if0.key_out, 32'h1234_5678);
        check("t1.lock1", if1.locked, 1);

        send_frame(32'h1234_5678, 8'h09, 0);
        check("t2.err0", if0.key_error, 1);
        check("t2.key0", if0.key_out, 0);
        check("t2.key1", if1.key_out, 32'h1234_5678);

        send_frame(32'h1234_5678, 8'h08, 1);
        check("t3.key0", if0.key_out, 32'h1234_5678);

        partial(21);
        send_frame(32'hDEAD_BEEF, 8'h22, 1);
        check("t4.key0", if0.key_out, 32'hDEAD_BEEF);

        for (int r = 0; r < 6; r++) begin
            k = $urandom;
            c = fold(k);
            if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
            send_frame(k, c, 1);
        end

        // bit_valid outside LOAD is ignored.
        repeat (8) begin
            bit_in = 1'($urandom); bit_valid = 1; step();
        end
        bit_valid = 0;
        check_outs("idle_bv");

        // Reset overrides a frame in progress.
        partial(15);
        rst = 1; bit_valid = 1; step(); rst = 0; bit_valid = 0;
        model_reset();
        check_outs("midrst");

        send_frame(32'hCAFE_F00D, fold(32'hCAFE_F00D), 1);
        check("t5.key1", if1.key_out, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=%0d", n_chk, 0);
        $fatal(1, "timeout");
    end
endmodule
